mem_port_seq: RTL and testbench

MEM_PORT_SEQ -- requirements
Module: mem_port_seq

---
 rtl/cpu_mem_pkg.sv | 16 +
 rtl/wait_timer.sv | 29 ++
 rtl/mem_port_seq.sv | 157 +++++++++++++++
 tb/tb_mem_port_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory port sequencer: bus width, timeout default, FSM states.
package cpu_mem_pkg;

    localparam int unsigned WORD_SIZE       = 16;
    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned WAIT_W          = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STORE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/wait_timer.sv
// Wait-cycle counter for a memory access; tc flags the last cycle an access may wait.
module wait_timer
    import cpu_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // One more idle wait from here makes the count reach TIMEOUT.
    assign tc = (r_count == WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_seq.sv
// Arbitrates fetch and data requests onto a single handshaked memory bus; all outputs registered.
module mem_port_seq #(
    parameter int unsigned WORD_SIZE = cpu_mem_pkg::WORD_SIZE,
    parameter int unsigned TIMEOUT   = cpu_mem_pkg::TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_grant,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 dm_req,
    input  logic                 dm_we,
    input  logic [WORD_SIZE-1:0] dm_addr,
    input  logic [WORD_SIZE-1:0] dm_wdata,
    output logic                 dm_done,
    output logic [WORD_SIZE-1:0] dm_rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 inputReady,
    output logic                 busy,
    output logic                 timeout_err
);
    import cpu_mem_pkg::*;

    state_t               r_state, w_next;
    logic                 r_is_dm, r_readM, r_writeM, r_busy, r_if_grant, r_dm_done, r_tmo;
    logic [1:0]           r_streak;
    logic [WORD_SIZE-1:0] r_addr, r_wdata, r_data_out, r_if_rdata, r_dm_rdata;

    logic                 w_is_dm, w_readM, w_writeM, w_busy, w_if_grant, w_dm_done, w_tmo;
    logic [1:0]           w_streak;
    logic [WORD_SIZE-1:0] w_addr, w_wdata, w_data_out, w_if_rdata, w_dm_rdata, w_rd_val;
    logic                 w_access, w_pick_if, w_pick_dm, w_finish, w_abort, w_tc;
    logic                 w_clear, w_enable;

    assign w_access  = (r_state == ST_FETCH) || (r_state == ST_LOAD) || (r_state == ST_STORE);
    // Fetch wins only when unopposed or after two data grants starved it.
    assign w_pick_if = if_req && (!dm_req || (r_streak == 2'd2));
    assign w_pick_dm = dm_req && !w_pick_if;
    assign w_finish  = w_access && (inputReady || w_tc);
    assign w_abort   = w_access && !inputReady && w_tc;
    assign w_clear   = !w_access;
    assign w_enable  = w_access && !inputReady;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_clear),
        .enable (w_enable),
        .tc     (w_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_dm)      w_next = dm_we ? ST_STORE : ST_LOAD;
                else if (w_pick_if) w_next = ST_FETCH;
            end
            ST_FETCH, ST_LOAD, ST_STORE: begin
                if (w_finish) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_addr     = r_addr;
        w_wdata    = r_wdata;
        w_is_dm    = r_is_dm;
        w_streak   = r_streak;
        w_if_rdata = r_if_rdata;
        w_dm_rdata = r_dm_rdata;
        w_rd_val   = inputReady ? data_in : '0;
        if (r_state == ST_IDLE) begin
            if (w_pick_dm) begin
                w_addr   = dm_addr;
                w_wdata  = dm_wdata;
                w_is_dm  = 1'b1;
                w_streak = if_req ? 2'(r_streak + 2'd1) : 2'd0;
            end else if (w_pick_if) begin
                w_addr   = if_addr;
                w_is_dm  = 1'b0;
                w_streak = 2'd0;
            end
        end
        // Stores leave dm_rdata alone unless they abort, which forces zero.
        if (w_finish && ((r_state != ST_STORE) || w_abort)) begin
            if (r_is_dm) w_dm_rdata = w_rd_val;
            else         w_if_rdata = w_rd_val;
        end
        w_readM    = (w_next == ST_FETCH) || (w_next == ST_LOAD);
        w_writeM   = (w_next == ST_STORE);
        w_busy     = (w_next != ST_IDLE);
        w_data_out = (w_next == ST_STORE) ? w_wdata : '0;
        w_if_grant = w_finish && !r_is_dm;
        w_dm_done  = w_finish && r_is_dm;
        w_tmo      = w_abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_is_dm    <= 1'b0;
            r_streak   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_readM    <= 1'b0;
            r_writeM   <= 1'b0;
            r_busy     <= 1'b0;
            r_data_out <= '0;
            r_if_grant <= 1'b0;
            r_dm_done  <= 1'b0;
            r_tmo      <= 1'b0;
        end else begin
            r_addr     <= w_addr;
            r_wdata    <= w_wdata;
            r_is_dm    <= w_is_dm;
            r_streak   <= w_streak;
            r_if_rdata <= w_if_rdata;
            r_dm_rdata <= w_dm_rdata;
            r_readM    <= w_readM;
            r_writeM   <= w_writeM;
            r_busy     <= w_busy;
            r_data_out <= w_data_out;
            r_if_grant <= w_if_grant;
            r_dm_done  <= w_dm_done;
            r_tmo      <= w_tmo;
        end
    end

    assign if_grant    = r_if_grant;
    assign if_rdata    = r_if_rdata;
    assign dm_done     = r_dm_done;
    assign dm_rdata    = r_dm_rdata;
    assign readM       = r_readM;
    assign writeM      = r_writeM;
    assign address     = r_addr;
    assign data_out    = r_data_out;
    assign busy        = r_busy;
    assign timeout_err = r_tmo;

endmodule

// File: tb/tb_mem_port_seq.sv
// Directed scoreboard bench for mem_port_seq: requester and memory models plus a pulse monitor.
module tb_mem_port_seq;

    typedef struct { bit is_dm; logic [15:0] rdata; bit chk; bit err; } resp_t;
    typedef struct { bit we; logic [15:0] addr; logic [15:0] wdata; } dmop_t;
    typedef struct { logic [15:0] addr; logic [15:0] wdata; } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_grant;
    logic [15:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic        dm_done;
    logic [15:0] dm_rdata;
    logic        readM, writeM, busy, timeout_err;
    logic [15:0] address, data_out, data_in;
    logic        inputReady;
    logic        rdy = 1'b0;
    logic        force_rdy = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int resp_delay = 2;
    bit resp_en = 1'b1;
    int last_len = 0;

    resp_t       exp_q[$];
    dmop_t       dm_q[$];
    logic [15:0] if_q[$];
    logic [15:0] rd_q[$];
    wr_t         wr_q[$];

    always #5 clk = ~clk;

    function automatic logic [15:0] rd_map(input logic [15:0] a);
        case (a)
            16'h0010: rd_map = 16'hA5A5;
            16'h0200: rd_map = 16'h1234;
            16'h0300: rd_map = 16'hBEEF;
            default:  rd_map = 16'hDEAD;
        endcase
    endfunction

    assign data_in    = rd_map(address);
    assign inputReady = rdy | force_rdy;

    mem_port_seq #(.WORD_SIZE(16), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata),
        .readM(readM), .writeM(writeM), .address(address), .data_out(data_out),
        .data_in(data_in), .inputReady(inputReady), .busy(busy), .timeout_err(timeout_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, expected none", name);
    endfunction

    // Requesters: hold each request until its grant/done, then present the next queued one.
    initial begin
        dmop_t op;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                if_req = 1'b0;
                dm_req = 1'b0;
            end else begin
                if (if_grant) if_req = 1'b0;
                if (dm_done)  dm_req = 1'b0;
                if (!if_req && if_q.size() > 0) begin
                    if_addr = if_q.pop_front();
                    if_req  = 1'b1;
                end
                if (!dm_req && dm_q.size() > 0) begin
                    op       = dm_q.pop_front();
                    dm_we    = op.we;
                    dm_addr  = op.addr;
                    dm_wdata = op.wdata;
                    dm_req   = 1'b1;
                end
            end
        end
    end

    // Memory: raise inputReady in strobe cycle resp_delay+1 when enabled.
    initial begin
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (readM || writeM) begin
                cyc++;
                rdy = (resp_en && cyc == resp_delay + 1);
            end else begin
                if (cyc != 0) last_len = cyc;
                cyc = 0;
                rdy = 1'b0;
            end
        end
    end

    // Monitor: bus checks every cycle, scoreboard pop on each grant/done pulse.
    initial begin
        bit    prev_rd = 1'b0;
        bit    prev_wr = 1'b0;
        wr_t   cur_wr;
        resp_t e;
        cur_wr = '{addr: 16'h0, wdata: 16'h0};
        forever begin
            @(negedge clk);
            check("rw_exclusive", 32'(readM & writeM), 32'h0);
            if (!writeM) check("data_out_zero", 32'(data_out), 32'h0);
            if (readM && !prev_rd) begin
                if (rd_q.size() == 0) flag("read_unexpected");
                else check("read_addr", 32'(address), 32'(rd_q.pop_front()));
            end
            if (writeM && !prev_wr) begin
                if (wr_q.size() == 0) flag("write_unexpected");
                else cur_wr = wr_q.pop_front();
            end
            if (writeM) begin
                check("write_data", 32'(data_out), 32'(cur_wr.wdata));
                check("write_addr", 32'(address), 32'(cur_wr.addr));
            end
            if (if_grant || dm_done) begin
                check("single_pulse", 32'(if_grant & dm_done), 32'h0);
                if (exp_q.size() == 0) begin
                    flag("pulse_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_port", 32'(dm_done), 32'(e.is_dm));
                    if (e.chk) check("resp_rdata", 32'(e.is_dm ? dm_rdata : if_rdata), 32'(e.rdata));
                    check("resp_timeout_err", 32'(timeout_err), 32'(e.err));
                end
            end else if (timeout_err) begin
                flag("timeout_err_stray");
            end
            prev_rd = readM;
            prev_wr = writeM;
        end
    end

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && if_q.size() == 0 && dm_q.size() == 0 &&
                !if_req && !dm_req && !busy) done = 1'b1;
        end
        check({name, "_complete"}, 32'(done), 32'h1);
        check({name, "_reads_left"}, 32'(rd_q.size()), 32'h0);
        check({name, "_writes_left"}, 32'(wr_q.size()), 32'h0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_busy"},     32'(busy), 32'h0);
        check({name, "_readM"},    32'(readM), 32'h0);
        check({name, "_writeM"},   32'(writeM), 32'h0);
        check({name, "_address"},  32'(address), 32'h0);
        check({name, "_data_out"}, 32'(data_out), 32'h0);
        check({name, "_if_rdata"}, 32'(if_rdata), 32'h0);
        check({name, "_dm_rdata"}, 32'(dm_rdata), 32'h0);
        check({name, "_pulses"},   32'({if_grant, dm_done, timeout_err}), 32'h0);
    endtask

    initial begin
        bit seen;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single fetch, inputReady two cycles after readM.
        resp_en = 1'b1; resp_delay = 2;
        exp_q.push_back('{is_dm: 1'b0, rdata: 16'hA5A5, chk: 1'b1, err: 1'b0});
        rd_q.push_back(16'h0010);
        if_q.push_back(16'h0010);
        drain("fetch");
        check("fetch_strobe_len", 32'(last_len), 32'd3);

        // Simultaneous load and fetch: load first.
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'h1234, chk: 1'b1, err: 1'b0});
        exp_q.push_back('{is_dm: 1'b0, rdata: 16'hA5A5, chk: 1'b1, err: 1'b0});
        rd_q.push_back(16'h0200);
        rd_q.push_back(16'h0010);
        dm_q.push_back('{we: 1'b0, addr: 16'h0200, wdata: 16'h0});
        if_q.push_back(16'h0010);
        drain("load_then_fetch");

        // Three stores with a fetch pending: store, store, fetch, store.
        resp_delay = 1;
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'h0, chk: 1'b0, err: 1'b0});
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'h0, chk: 1'b0, err: 1'b0});
        exp_q.push_back('{is_dm: 1'b0, rdata: 16'hA5A5, chk: 1'b1, err: 1'b0});
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'h0, chk: 1'b0, err: 1'b0});
        wr_q.push_back('{addr: 16'h0100, wdata: 16'h1111});
        wr_q.push_back('{addr: 16'h0104, wdata: 16'h2222});
        wr_q.push_back('{addr: 16'h0108, wdata: 16'h3333});
        rd_q.push_back(16'h0010);
        dm_q.push_back('{we: 1'b1, addr: 16'h0100, wdata: 16'h1111});
        dm_q.push_back('{we: 1'b1, addr: 16'h0104, wdata: 16'h2222});
        dm_q.push_back('{we: 1'b1, addr: 16'h0108, wdata: 16'h3333});
        if_q.push_back(16'h0010);
        drain("store_fairness");
        check("store_keeps_dm_rdata", 32'(dm_rdata), 32'h1234);

        // inputReady on the terminal-count cycle: data wins, no error.
        resp_delay = 3;
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'hBEEF, chk: 1'b1, err: 1'b0});
        rd_q.push_back(16'h0300);
        dm_q.push_back('{we: 1'b0, addr: 16'h0300, wdata: 16'h0});
        drain("ready_at_tc");
        check("ready_at_tc_len", 32'(last_len), 32'd4);

        // No response at all: abort after 4 waits with zero data and error.
        resp_en = 1'b0;
        exp_q.push_back('{is_dm: 1'b1, rdata: 16'h0, chk: 1'b1, err: 1'b1});
        rd_q.push_back(16'h0300);
        dm_q.push_back('{we: 1'b0, addr: 16'h0300, wdata: 16'h0});
        drain("timeout");
        check("timeout_len", 32'(last_len), 32'd4);

        // Stray inputReady in IDLE.
        force_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_ready_busy", 32'(busy), 32'h0);
            check("idle_ready_strobes", 32'({readM, writeM}), 32'h0);
        end
        force_rdy = 1'b0;

        // Reset while readM is high: immediate clear, no pulse.
        rd_q.push_back(16'h0010);
        if_q.push_back(16'h0010);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (readM) seen = 1'b1;
        end
        check("reset_mid_readM_seen", 32'(seen), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check("reset_mid_readM", 32'(readM), 32'h0);
        check("reset_mid_busy", 32'(busy), 32'h0);
        check("reset_mid_address", 32'(address), 32'h0);
        check("reset_mid_if_rdata", 32'(if_rdata), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'h0);

        // Requester retries after reset.
        resp_en = 1'b1; resp_delay = 1;
        exp_q.push_back('{is_dm: 1'b0, rdata: 16'hA5A5, chk: 1'b1, err: 1'b0});
        rd_q.push_back(16'h0010);
        if_q.push_back(16'h0010);
        drain("retry_fetch");
        check("retry_len", 32'(last_len), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
